// File: rtl/bin_2c_pkg.sv
// Shared types and constants for the two's-complement to BCD display controller.
package bin_2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  localparam logic [3:0]  BLANK_CODE     = 4'hF;
  localparam logic [3:0]  MINUS_CODE     = 4'hA;
  localparam int unsigned DEFAULT_DW     = 8;
  localparam int unsigned DEFAULT_DIGITS = 3;

  // 10^n, used to check that DIGITS can hold the largest magnitude.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3_adjust.sv
// Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
module bcd_add3_adjust
  import bin_2c_pkg::*;
#(
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic [4*DIGITS-1:0] d_in,
  output logic [4*DIGITS-1:0] d_out
);

  // Per-digit conditional add of 3.
  always_comb begin
    d_out = d_in;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (d_in[4*k +: 4] >= 4'd5) begin
        d_out[4*k +: 4] = d_in[4*k +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bin_2c_display_controller.sv
// Two's-complement word to sign + BCD digits, one bit per clock, with
// leading-zero blanking. Optional digit scan multiplexing: SCAN_MUX_EN.
module bin_2c_display_controller
  import bin_2c_pkg::*;
#(
  parameter int unsigned DW       = DEFAULT_DW,
  parameter int unsigned DIGITS   = DEFAULT_DIGITS,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic                minus_sign,
  output logic [4*DIGITS-1:0] bcd_digits
`ifdef SCAN_MUX_EN
  ,
  output logic [3:0]          scan_bcd,
  output logic [DIGITS:0]     scan_sel
`endif
);

  localparam int unsigned CNTW = $clog2(DW + 1);

  if (pow10(DIGITS) <= (64'd1 << (DW - 1))) begin : g_digits_too_few
    $error("DIGITS cannot represent the largest magnitude of a DW-bit word");
  end
  if (SCAN_DIV == 0) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [DW-1:0]         mag_q, mag_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  minus_q, minus_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   blanked;
  logic                  seen_nz;

  bcd_add3_adjust #(.DIGITS(DIGITS)) u_adjust (
    .d_in  (acc_q),
    .d_out (adj)
  );

  // Leading-zero blanking of the finished accumulator; digit 0 always shown.
  always_comb begin
    blanked = acc_q;
    seen_nz = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (acc_q[4*(DIGITS-1-k) +: 4] != 4'h0) begin
        seen_nz = 1'b1;
      end
      if (!seen_nz && (k != DIGITS - 1)) begin
        blanked[4*(DIGITS-1-k) +: 4] = BLANK_CODE;
      end
    end
  end

  // FSM next-state and datapath: capture, DW shift-and-add-3 steps, load.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    minus_d = minus_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[DW-1];
          mag_d   = in_data[DW-1] ? (~in_data + 1'b1) : in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {acc_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(DW - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        disp_d  = blanked;
        minus_d = sign_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and display registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      disp_q      <= '1;
      disp_q[3:0] <= 4'h0;
      minus_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      minus_q <= minus_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign minus_sign = minus_q;
  assign bcd_digits = disp_q;

`ifdef SCAN_MUX_EN
  localparam int unsigned SCW = $clog2(SCAN_DIV + 1);
  localparam int unsigned IW  = $clog2(DIGITS + 1);

  logic [SCW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic [3:0]      scan_bcd_q, scan_bcd_d;
  logic [DIGITS:0] scan_sel_q, scan_sel_d;

  // Free-running slot timer; outputs are built from the next slot and next
  // display value so the registered scan outputs line up with the slot index.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IW'(DIGITS)) ? '0 : scan_idx_q + 1'b1;
    end
    scan_sel_d = '1;
    scan_bcd_d = minus_d ? MINUS_CODE : BLANK_CODE;
    for (int unsigned k = 0; k <= DIGITS; k++) begin
      if (scan_idx_d == IW'(k)) begin
        scan_sel_d[k] = 1'b0;
      end
    end
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scan_idx_d == IW'(k)) begin
        scan_bcd_d = disp_d[4*k +: 4];
      end
    end
  end

  // Scan registers; only rst restarts the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      scan_idx_q    <= '0;
      scan_sel_q    <= '1;
      scan_sel_q[0] <= 1'b0;
      scan_bcd_q    <= 4'h0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      scan_sel_q <= scan_sel_d;
      scan_bcd_q <= scan_bcd_d;
    end
  end

  assign scan_bcd = scan_bcd_q;
  assign scan_sel = scan_sel_q;
`endif

endmodule

// File: tb/tb_bin_2c_display_controller.sv
// Scoreboard bench for bin_2c_display_controller (DW=8, DIGITS=3).
module tb_bin_2c_display_controller;

  localparam int unsigned DW     = 8;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned LAT    = DW + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [DW-1:0]       in_data;
  logic                in_valid;
  logic                in_ready;
  logic                busy;
  logic                done;
  logic                minus_sign;
  logic [4*DIGITS-1:0] bcd_digits;
`ifdef SCAN_MUX_EN
  logic [3:0]          scan_bcd;
  logic [DIGITS:0]     scan_sel;
`endif

  bin_2c_display_controller #(.DW(DW), .DIGITS(DIGITS), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .minus_sign (minus_sign),
    .bcd_digits (bcd_digits)
`ifdef SCAN_MUX_EN
    ,
    .scan_bcd   (scan_bcd),
    .scan_sel   (scan_sel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*DIGITS-1:0] dig;
    logic                neg;
    int                  acc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   acc_prev    = 0;
  int   acc_last    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed decimal conversion with leading-zero blanking.
  function automatic exp_t model(input logic [DW-1:0] v);
    exp_t e;
    int   s, m, d;
    logic seen;
    logic [4*DIGITS-1:0] raw;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    e.neg = (s < 0);
    for (int k = 0; k < DIGITS; k++) begin
      d = m % 10;
      raw[4*k +: 4] = 4'(d);
      m = m / 10;
    end
    e.dig = raw;
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (raw[4*k +: 4] != 4'h0) seen = 1'b1;
      if (!seen) e.dig[4*k +: 4] = 4'hF;
    end
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Push the expected result when a handshake is taken.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e = model(in_data);
      e.acc = cyc;
      sb.push_back(e);
      acc_prev = acc_last;
      acc_last = cyc;
    end
  end

  // Pop and compare on each done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("digits", 32'(bcd_digits), 32'(e.dig));
        check("minus", 32'(minus_sign), 32'(e.neg));
        check("latency", 32'(cyc - e.acc), 32'(LAT));
        check("ready_on_done", 32'(in_ready), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic send(input logic [DW-1:0] v);
    int n;
    in_data  = v;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 40);
    check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_minus", 32'(minus_sign), 32'd0);
    check("rst_digits", 32'(bcd_digits), 32'h0FF0);

    // Directed values, including both extremes and zero.
    send(8'h05);
    send(8'h80);
    send(8'hFF);
    send(8'h7F);
    send(8'h00);
    for (int i = 0; i < 6; i++) send(DW'($urandom_range(0, 255)));

    // in_valid held: second word taken only on the done cycle.
    @(negedge clk);
    in_data  = 8'h0A;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'hF6;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("held_ready_lo", 32'(in_ready), 32'd0);
      check("held_busy_hi", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("held_ready_t10", 32'(in_ready), 32'd1);
    check("held_done_t10", 32'(done), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
    check("held_accept_gap", 32'(acc_last - acc_prev), 32'(LAT));
    @(negedge clk);
    check("held_digits", 32'(bcd_digits), 32'h0F10);
    check("held_minus", 32'(minus_sign), 32'd1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    in_data  = 8'h63;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_minus", 32'(minus_sign), 32'd0);
    check("abort_digits", 32'(bcd_digits), 32'h0FF0);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(sb.size()), 32'd0);

`ifdef SCAN_MUX_EN
    begin
      logic [DIGITS:0] prev_sel;
      logic [3:0]      exp_bcd [0:DIGITS];
      int              n;
      send(8'hF3);
      exp_bcd[0] = 4'h3;
      exp_bcd[1] = 4'h1;
      exp_bcd[2] = 4'hF;
      exp_bcd[3] = 4'hA;
      @(negedge clk);
      prev_sel = scan_sel;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (scan_sel == 4'b1110 && prev_sel != 4'b1110) break;
        prev_sel = scan_sel;
      end while (n < 40);
      check("scan_sync", 32'(scan_sel), 32'h0E);
      for (int s = 0; s <= DIGITS + 1; s++) begin
        for (int c = 0; c < 4; c++) begin
          if (s != 0 || c != 0) @(negedge clk);
          check("scan_sel", 32'(scan_sel), 32'(~(4'b0001 << (s % (DIGITS + 1)))));
          check("scan_bcd", 32'(scan_bcd), 32'(exp_bcd[s % (DIGITS + 1)]));
        end
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
